// File: rtl/scale_matrix_ctrl.sv
// Two-requester round-robin controller that scales a 4x4 matrix of 16-bit
// elements by an 8-bit scalar, one element per cycle.
module scale_matrix_ctrl #(
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [255:0] matrix0,
    input  logic [7:0]   scalar0,
    input  logic         req1,
    input  logic [255:0] matrix1,
    input  logic [7:0]   scalar1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [255:0] m_out,
    output logic         busy,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q;
    logic [3:0]     idx_q;
    logic [255:0]   mat_q;
    logic [7:0]     scl_q;
    logic [255:0]   res_q;
    logic [255:0]   res_d;
    logic           acc_q;
    logic           owner_q;
    logic           last_q;
    logic           gnt0_q, gnt1_q, done0_q, done1_q;
    logic [255:0]   m_out_q;
    logic           ovf_q;

    logic           any_req;
    logic           pick1;
    logic [15:0]    elem_in;
    logic [23:0]    prod;
    logic           elem_ovf;
    logic [15:0]    elem_res;

    // last_q records the requester granted most recently; resetting it to 1
    // hands the first contended grant to requester 0.
    always_comb begin
        any_req  = req0 | req1;
        pick1    = req1 & (~req0 | ~last_q);
        elem_in  = mat_q[{idx_q, 4'h0} +: 16];
        prod     = {8'h00, elem_in} * {16'h0000, scl_q};
        elem_ovf = |prod[23:16];
        elem_res = (elem_ovf && SAT) ? 16'hFFFF : prod[15:0];
        res_d    = res_q;
        res_d[{idx_q, 4'h0} +: 16] = elem_res;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mat_q   <= '0;
            scl_q   <= '0;
            res_q   <= '0;
            acc_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            m_out_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                // DONE arbitrates like IDLE so a waiting requester is granted back-to-back
                IDLE, DONE: begin
                    if (any_req) begin
                        state_q <= RUN;
                        owner_q <= pick1;
                        last_q  <= pick1;
                        gnt0_q  <= ~pick1;
                        gnt1_q  <= pick1;
                        mat_q   <= pick1 ? matrix1 : matrix0;
                        scl_q   <= pick1 ? scalar1 : scalar0;
                        idx_q   <= '0;
                        acc_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    acc_q <= acc_q | elem_ovf;
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_q <= DONE;
                        m_out_q <= res_d;
                        ovf_q   <= acc_q | elem_ovf;
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign m_out = m_out_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_scale_matrix_ctrl.sv
// Scoreboard bench for scale_matrix_ctrl: a truncating and a saturating
// instance share stimulus; a monitor checks every done against queued results.
module tb_scale_matrix_ctrl;

    typedef logic [15:0] v16_t [16];
    typedef struct {
        bit           id;
        logic [255:0] m;
        bit           ov;
        logic [255:0] ms;
        bit           ovs;
        int unsigned  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1;
    logic [255:0] matrix0, matrix1;
    logic [7:0]   scalar0, scalar1;
    logic         gnt0, gnt1, done0, done1, busy, ovf;
    logic [255:0] m_out;
    logic         gnt0_s, gnt1_s, done0_s, done1_s, busy_s, ovf_s;
    logic [255:0] m_out_s;

    exp_t         q[$];
    int unsigned  cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [255:0] last_m = '0, last_ms = '0;
    logic         last_ov = 1'b0, last_ovs = 1'b0;

    logic [255:0] A, A2, A5, B, B3, C, C8t, C8s, D, F;

    scale_matrix_ctrl #(.SAT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .matrix0(matrix0), .scalar0(scalar0),
        .req1(req1), .matrix1(matrix1), .scalar1(scalar1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .m_out(m_out), .busy(busy), .ovf(ovf)
    );

    scale_matrix_ctrl #(.SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset),
        .req0(req0), .matrix0(matrix0), .scalar0(scalar0),
        .req1(req1), .matrix1(matrix1), .scalar1(scalar1),
        .gnt0(gnt0_s), .gnt1(gnt1_s), .done0(done0_s), .done1(done1_s),
        .m_out(m_out_s), .busy(busy_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] pack(input v16_t v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = v[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse; between dones, m_out/ovf must hold.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (gnt0 || gnt1 || done0 || done1)
                chk("onehot", {254'd0, gnt0 & gnt1, done0 & done1}, '0);
            if (done0 || done1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done actual=%b%b required=00 t=%0t", done1, done0, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_id", {done1, done0}, 2'b01 << e.id);
                    chk("done_cyc", cyc, e.cyc);
                    chk("m_out", m_out, e.m);
                    chk("ovf", ovf, e.ov);
                    chk("sat_done", {done1_s, done0_s}, 2'b01 << e.id);
                    chk("sat_m_out", m_out_s, e.ms);
                    chk("sat_ovf", ovf_s, e.ovs);
                    last_m = e.m; last_ov = e.ov; last_ms = e.ms; last_ovs = e.ovs;
                end
            end else if (busy) begin
                chk("hold_m_out", m_out, last_m);
                chk("hold_ovf", ovf, last_ov);
                chk("hold_sat_m_out", m_out_s, last_ms);
            end
        end
    end

    // Waits for the next grant, checks who and when, then queues the expected result.
    task automatic expect_gnt(input bit id, input int unsigned exp_cyc,
                              input logic [255:0] em, input bit eo,
                              input logic [255:0] ems, input bit eos);
        bit got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout actual=none required=gnt%0d", id);
        end else begin
            chk("gnt_id", {gnt1, gnt0}, 2'b01 << id);
            chk("sat_gnt_id", {gnt1_s, gnt0_s}, 2'b01 << id);
            chk("gnt_cyc", cyc, exp_cyc);
            e.id = id; e.m = em; e.ov = eo; e.ms = ems; e.ovs = eos; e.cyc = cyc + 16;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d_pending required=0", q.size());
            q.delete();
        end
    endtask

    task automatic do_op(input bit id, input logic [255:0] m, input logic [7:0] s,
                         input logic [255:0] em, input bit eo,
                         input logic [255:0] ems, input bit eos, input bit corrupt);
        int unsigned c0;
        @(negedge clk);
        if (id) begin req1 = 1'b1; matrix1 = m; scalar1 = s; end
        else    begin req0 = 1'b1; matrix0 = m; scalar0 = s; end
        c0 = cyc;
        expect_gnt(id, c0 + 1, em, eo, ems, eos);
        req0 = 1'b0;
        req1 = 1'b0;
        if (corrupt) begin
            matrix0 = '1; matrix1 = '1; scalar0 = 8'hFF; scalar1 = 8'hFF;
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned g;
        A   = pack('{16'd5, 16'd8, 16'd9, 16'd2, 16'd7, 16'd3, 16'd8, 16'd4,
                     16'd6, 16'd5, 16'd4, 16'd3, 16'd8, 16'd5, 16'd7, 16'd6});
        A2  = pack('{16'd10, 16'd16, 16'd18, 16'd4, 16'd14, 16'd6, 16'd16, 16'd8,
                     16'd12, 16'd10, 16'd8, 16'd6, 16'd16, 16'd10, 16'd14, 16'd12});
        A5  = pack('{16'd25, 16'd40, 16'd45, 16'd10, 16'd35, 16'd15, 16'd40, 16'd20,
                     16'd30, 16'd25, 16'd20, 16'd15, 16'd40, 16'd25, 16'd35, 16'd30});
        B   = pack('{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
                     16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16});
        B3  = pack('{16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18, 16'd21, 16'd24,
                     16'd27, 16'd30, 16'd33, 16'd36, 16'd39, 16'd42, 16'd45, 16'd48});
        C   = {16{16'h0100}};
        C[3*16 +: 16] = 16'h4000;
        C8t = {16{16'h0800}};
        C8t[3*16 +: 16] = 16'h0000;
        C8s = {16{16'h0800}};
        C8s[3*16 +: 16] = 16'hFFFF;
        D   = pack('{16'hFFFF, 16'h1234, 16'h8000, 16'h0001, 16'hABCD, 16'h0000, 16'h7FFF, 16'h5555,
                     16'hAAAA, 16'h00FF, 16'hFF00, 16'h0F0F, 16'hF0F0, 16'h4000, 16'h2468, 16'hFFFE});
        F   = '1;

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        matrix0 = '0; matrix1 = '0; scalar0 = '0; scalar1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {gnt0, gnt1, done0, done1, busy, ovf}, '0);
        chk("rst_m_out", m_out, '0);
        chk("rst_sat_flags", {gnt0_s, gnt1_s, done0_s, done1_s, busy_s, ovf_s}, '0);
        #2 reset = 1'b1;

        // Contention: both request from reset, requester 1 waits, then a third round.
        @(negedge clk);
        req0 = 1'b1; matrix0 = A; scalar0 = 8'd2;
        req1 = 1'b1; matrix1 = B; scalar1 = 8'd3;
        g = cyc;
        expect_gnt(1'b0, g + 1, A2, 1'b0, A2, 1'b0);
        req0 = 1'b0;
        g = cyc;
        expect_gnt(1'b1, g + 17, B3, 1'b0, B3, 1'b0);
        g = cyc;
        req1 = 1'b1;
        req0 = 1'b1; matrix0 = A; scalar0 = 8'd5;
        expect_gnt(1'b0, g + 17, A5, 1'b0, A5, 1'b0);
        req0 = 1'b0;
        g = cyc;
        expect_gnt(1'b1, g + 17, B3, 1'b0, B3, 1'b0);
        req1 = 1'b0;
        drain();

        do_op(1'b0, F, 8'd0, '0, 1'b0, '0, 1'b0, 1'b0);
        do_op(1'b0, C, 8'd8, C8t, 1'b1, C8s, 1'b1, 1'b0);
        do_op(1'b1, D, 8'd1, D, 1'b0, D, 1'b0, 1'b0);
        do_op(1'b0, A, 8'd5, A5, 1'b0, A5, 1'b0, 1'b1);

        // Abort at idx 7: no done may follow, and a fresh request must work normally.
        @(negedge clk);
        req0 = 1'b1; matrix0 = B; scalar0 = 8'd3;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) break;
        end
        chk("abort_gnt", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        last_m = '0; last_ov = 1'b0; last_ms = '0; last_ovs = 1'b0;
        #1;
        chk("abort_busy", {busy, busy_s}, '0);
        chk("abort_m_out", m_out, '0);
        chk("abort_flags", {gnt0, gnt1, done0, done1, ovf}, '0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_idle", busy, 1'b0);
        do_op(1'b1, A, 8'd2, A2, 1'b0, A2, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
